// File: rtl/multicycle_ctrl.sv
// Control FSM for a shared-ALU multicycle datapath: fetch, decode, execute,
// memory and writeback sequencing with a timed memory handshake and a
// retired-instruction counter.
//
// Memory handshake: mem_read / mem_write form the request. The request is
// held steady from the cycle the requesting state is entered until the cycle
// mem_ready is seen high. If mem_ready stays low for MEM_TIMEOUT cycles, the
// request is abandoned and the FSM returns to FETCH. During the following
// cycle bus_err pulses and every request and write enable is held low. FETCH
// does not advance in that cycle. mem_ready in the last allowed cycle still
// completes the access.
//
// state_dbg exposes the current state encoding for observation.
module multicycle_ctrl #(
   parameter int WIDTH       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             reg_dst,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic             illegal,
   output logic             bus_err,
   output logic [WIDTH-1:0] instr_count,
   output logic [3:0]       state_dbg
);

   localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J   = 6'b000010;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXECUTE   = 4'd7,
      S_ALU_WB    = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10
   } state_e;

   state_e           state_q, state_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic [WIDTH-1:0] count_q;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;
   logic             retire;
   logic             mem_wait;
   logic             timeout;

   // State, wait counter, retire counter and the registered error pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         wait_q    <= '0;
         count_q   <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
         if (retire) count_q <= count_q + WIDTH'(1);
      end
   end

   // Next-state, retire, error pulses and memory wait/timeout tracking.
   always_comb begin
      state_d   = state_q;
      illegal_d = 1'b0;
      bus_err_d = 1'b0;
      retire    = 1'b0;
      mem_wait  = 1'b0;
      case (state_q)
         S_IDLE:      if (run) state_d = S_FETCH;
         S_FETCH: begin
            mem_wait = !bus_err_q;
            if (!bus_err_q && mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_R:         state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ: begin
            mem_wait = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WRITE: begin
            mem_wait = 1'b1;
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXECUTE:   state_d = S_ALU_WB;
         S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         default:     state_d = S_IDLE;
      endcase
      // A late mem_ready on the last allowed cycle takes priority over the timeout.
      timeout = mem_wait && !mem_ready && (wait_q == WAIT_LAST);
      if (timeout) begin
         state_d   = S_FETCH;
         bus_err_d = 1'b1;
      end
      wait_d = (mem_wait && !mem_ready && !timeout) ? wait_q + WW'(1) : '0;
   end

   // Moore control decode; FETCH's IR/PC loads also wait for mem_ready.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_read  = !bus_err_q;
            alu_src_b = 2'b01;
            ir_write  = mem_ready && !bus_err_q;
            pc_write  = mem_ready && !bus_err_q;
         end
         S_DECODE:    alu_src_b = 2'b11;
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         default: ;
      endcase
   end

   assign illegal     = illegal_q;
   assign bus_err     = bus_err_q;
   assign instr_count = count_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected state/pulse
// queue, a control-word table, and a retired-instruction model.
module tb_multicycle_ctrl;
   localparam int WIDTH       = 8;
   localparam int MEM_TIMEOUT = 4;

   localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
      S_MEM_ADDR = 4'd3, S_MEM_READ = 4'd4, S_MEM_WB = 4'd5, S_MEM_WRITE = 4'd6,
      S_EXECUTE = 4'd7, S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10;
   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
      OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_BAD = 6'b111111;

   // Queue entry flags: bit 5 = bus_err expected, bit 4 = illegal expected.
   localparam logic [5:0] F_ILL = 6'b010000;
   localparam logic [5:0] F_BERR = 6'b100000;

   // Clock and reset.
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             run = 1'b0;
   logic [5:0]       opcode = 6'b0;
   logic             mem_ready = 1'b0;
   logic             pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic             mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]       alu_src_b, alu_op, pc_source;
   logic             illegal, bus_err;
   logic [WIDTH-1:0] instr_count;
   logic [3:0]       state_dbg;
   logic [15:0]      ctrl;

   multicycle_ctrl #(.WIDTH(WIDTH), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal(illegal), .bus_err(bus_err),
      .instr_count(instr_count), .state_dbg(state_dbg)
   );

   assign ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

   // Scoreboard: expected {bus_err, illegal, state} per cycle plus the mem_ready to apply.
   logic [5:0]       exp_q[$];
   logic             rdy_q[$];
   logic [WIDTH-1:0] model_cnt = '0;
   int               n_checks = 0;
   int               n_pass = 0;

   // Control word required by the state table for one cycle.
   function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic berr);
      logic pcw, pcwc, io, mrd, mwr, irw, m2r, rd, rw, asa;
      logic [1:0] asb, aop, psrc;
      {pcw, pcwc, io, mrd, mwr, irw, m2r, rd, rw, asa} = '0;
      asb = 2'b00; aop = 2'b00; psrc = 2'b00;
      case (st)
         S_FETCH:     begin mrd = !berr; asb = 2'b01; irw = mr && !berr; pcw = mr && !berr; end
         S_DECODE:    asb = 2'b11;
         S_MEM_ADDR:  begin asa = 1'b1; asb = 2'b10; end
         S_MEM_READ:  begin mrd = 1'b1; io = 1'b1; end
         S_MEM_WB:    begin rw = 1'b1; m2r = 1'b1; end
         S_MEM_WRITE: begin mwr = 1'b1; io = 1'b1; end
         S_EXECUTE:   begin asa = 1'b1; aop = 2'b10; end
         S_ALU_WB:    begin rw = 1'b1; rd = 1'b1; end
         S_BRANCH:    begin asa = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
         S_JUMP:      begin pcw = 1'b1; psrc = 2'b10; end
         default: ;
      endcase
      return {pcw, pcwc, io, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc};
   endfunction

   // Driver: advance one clock and apply this cycle's inputs, then settle.
   task automatic step(input logic mr, input logic [5:0] op);
      @(posedge clk);
      #1;
      mem_ready = mr;
      opcode    = op;
      #1;
   endtask

   task automatic push(input logic [5:0] e, input logic mr);
      exp_q.push_back(e);
      rdy_q.push_back(mr);
   endtask

   task automatic push_wait(input logic [3:0] st, input int waits);
      for (int i = 0; i < waits; i++) push({2'b00, st}, 1'b0);
      push({2'b00, st}, 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (state_dbg !== S_IDLE || ctrl !== 16'h0 || {bus_err, illegal} !== 2'b00 || instr_count !== '0)
         $display("FAIL reset: state=%0d ctrl=%h berr/ill=%b%b count=%0d, expected state 0 ctrl 0 pulses 0 count 0",
                  state_dbg, ctrl, bus_err, illegal, instr_count);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_r_type();
      logic [5:0] e;
      logic       mr;
      run = 1'b1;
      push({2'b00, S_FETCH}, 1'b1);
      push({2'b00, S_DECODE}, 1'b1);
      push({2'b00, S_EXECUTE}, 1'b1);
      push({2'b00, S_ALU_WB}, 1'b1);
      push({2'b00, S_FETCH}, 1'b1);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); mr = rdy_q.pop_front();
         step(mr, OP_R);
         run = 1'b0;
         n_checks++;
         if ({bus_err, illegal, state_dbg} !== e || ctrl !== exp_ctrl(e[3:0], mr, e[5]))
            $display("FAIL r_type: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                     state_dbg, ctrl, e[3:0], exp_ctrl(e[3:0], mr, e[5]));
         else n_pass++;
      end
      model_cnt = model_cnt + 1'b1;
      n_checks++;
      if (instr_count !== model_cnt) $display("FAIL r_type count: got %0d expected %0d", instr_count, model_cnt);
      else n_pass++;
   endtask

   task automatic test_lw_wait();
      logic [5:0] e;
      logic       mr;
      push({2'b00, S_DECODE}, 1'b1);
      push({2'b00, S_MEM_ADDR}, 1'b1);
      push_wait(S_MEM_READ, 3);
      push({2'b00, S_MEM_WB}, 1'b1);
      push({2'b00, S_FETCH}, 1'b1);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); mr = rdy_q.pop_front();
         step(mr, OP_LW);
         n_checks++;
         if ({bus_err, illegal, state_dbg} !== e || ctrl !== exp_ctrl(e[3:0], mr, e[5]))
            $display("FAIL lw_wait: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                     state_dbg, ctrl, e[3:0], exp_ctrl(e[3:0], mr, e[5]));
         else n_pass++;
      end
      model_cnt = model_cnt + 1'b1;
      n_checks++;
      if (instr_count !== model_cnt) $display("FAIL lw_wait count: got %0d expected %0d", instr_count, model_cnt);
      else n_pass++;
   endtask

   task automatic test_beq();
      logic [5:0] e;
      logic       mr;
      push({2'b00, S_DECODE}, 1'b1);
      push({2'b00, S_BRANCH}, 1'b1);
      push({2'b00, S_FETCH}, 1'b1);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); mr = rdy_q.pop_front();
         step(mr, OP_BEQ);
         n_checks++;
         if ({bus_err, illegal, state_dbg} !== e || ctrl !== exp_ctrl(e[3:0], mr, e[5]))
            $display("FAIL beq: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                     state_dbg, ctrl, e[3:0], exp_ctrl(e[3:0], mr, e[5]));
         else n_pass++;
      end
      model_cnt = model_cnt + 1'b1;
      n_checks++;
      if (instr_count !== model_cnt) $display("FAIL beq count: got %0d expected %0d", instr_count, model_cnt);
      else n_pass++;
   endtask

   task automatic test_illegal_then_jump();
      logic [5:0] e;
      logic       mr;
      push({2'b00, S_DECODE}, 1'b1);
      push(F_ILL | {2'b00, S_FETCH}, 1'b1);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); mr = rdy_q.pop_front();
         step(mr, OP_BAD);
         n_checks++;
         if ({bus_err, illegal, state_dbg} !== e || ctrl !== exp_ctrl(e[3:0], mr, e[5]))
            $display("FAIL illegal: state=%0d ill=%b ctrl=%h, expected state=%0d ill=%b ctrl=%h",
                     state_dbg, illegal, ctrl, e[3:0], e[4], exp_ctrl(e[3:0], mr, e[5]));
         else n_pass++;
      end
      n_checks++;
      if (instr_count !== model_cnt) $display("FAIL illegal count: got %0d expected %0d", instr_count, model_cnt);
      else n_pass++;
      push({2'b00, S_DECODE}, 1'b1);
      push({2'b00, S_JUMP}, 1'b1);
      push({2'b00, S_FETCH}, 1'b1);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front(); mr = rdy_q.pop_front();
         step(mr, OP_J);
         n_checks++;
         if ({bus_err, illegal, state_dbg} !== e || ctrl !== exp_ctrl(e[3:0], mr, e[5]))
            $display("FAIL jump: state=%0d ill=%b ctrl=%h, expected state=%0d ill=%b ctrl=%h",
                     state_dbg, illegal, ctrl, e[3:0], e[4], exp_ctrl(e[3:0], mr, e[5]));
         else n_pass++;
      end
      model_cnt = model_cnt + 1'b1;
      n_checks++;
      if (instr_count !== model_cnt) $display("FAIL jump count: got %0d expected %0d", instr_count, model_cnt);
      else n_pass++;
   endtask

   task automatic test_sw_timeout();
      logic [5:0] e;
      logic       mr;
      // Full timeout: four cycles of mem_write, then an error cycle in FETCH.
      push({2'b00, S_DECODE}, 1'b1);
      push({2'b00, S_MEM_ADDR}, 1'b1);
      for (int i = 0; i < MEM_TIMEOUT; i++) push({2'b00, S_MEM_WRITE}, 1'b0);
      push(F_BERR | {2'b00, S_FETCH}, 1'b1);
      push({2'b00, S_FETCH}, 1'b1);
      // Same store with mem_ready arriving on the last allowed cycle.
      push({2'b00, S_DECODE}, 1'b1);
      push({2'b00, S_MEM_ADDR}, 1'b1);
      push_wait(S_MEM_WRITE, MEM_TIMEOUT - 1);
      push({2'b00, S_FETCH}, 1'b1);
      while (exp_q.size() != 0) begin
         if (exp_q.size() == 5) begin
            n_checks++;
            if (instr_count !== model_cnt) $display("FAIL sw_timeout no-retire: got %0d expected %0d", instr_count, model_cnt);
            else n_pass++;
         end
         e = exp_q.pop_front(); mr = rdy_q.pop_front();
         step(mr, OP_SW);
         n_checks++;
         if ({bus_err, illegal, state_dbg} !== e || ctrl !== exp_ctrl(e[3:0], mr, e[5]))
            $display("FAIL sw_timeout: state=%0d berr=%b ctrl=%h, expected state=%0d berr=%b ctrl=%h",
                     state_dbg, bus_err, ctrl, e[3:0], e[5], exp_ctrl(e[3:0], mr, e[5]));
         else n_pass++;
      end
      model_cnt = model_cnt + 1'b1;
      n_checks++;
      if (instr_count !== model_cnt) $display("FAIL sw_late_ready count: got %0d expected %0d", instr_count, model_cnt);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [5:0] e;
      logic       mr;
      logic [5:0] op;
      for (int n = 0; n < 20; n++) begin
         case ($urandom_range(0, 4))
            0: op = OP_R;
            1: op = OP_LW;
            2: op = OP_SW;
            3: op = OP_BEQ;
            default: op = OP_J;
         endcase
         push({2'b00, S_DECODE}, 1'b1);
         case (op)
            OP_R:   begin push({2'b00, S_EXECUTE}, 1'b1); push({2'b00, S_ALU_WB}, 1'b1); end
            OP_LW:  begin push({2'b00, S_MEM_ADDR}, 1'b1);
                          push_wait(S_MEM_READ, $urandom_range(0, MEM_TIMEOUT - 1));
                          push({2'b00, S_MEM_WB}, 1'b1); end
            OP_SW:  begin push({2'b00, S_MEM_ADDR}, 1'b1);
                          push_wait(S_MEM_WRITE, $urandom_range(0, MEM_TIMEOUT - 1)); end
            OP_BEQ: push({2'b00, S_BRANCH}, 1'b1);
            default: push({2'b00, S_JUMP}, 1'b1);
         endcase
         push_wait(S_FETCH, $urandom_range(0, MEM_TIMEOUT - 1));
         while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); mr = rdy_q.pop_front();
            step(mr, op);
            n_checks++;
            if ({bus_err, illegal, state_dbg} !== e || ctrl !== exp_ctrl(e[3:0], mr, e[5]))
               $display("FAIL random op=%b: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                        op, state_dbg, ctrl, e[3:0], exp_ctrl(e[3:0], mr, e[5]));
            else n_pass++;
         end
         model_cnt = model_cnt + 1'b1;
         n_checks++;
         if (instr_count !== model_cnt) $display("FAIL random count: got %0d expected %0d", instr_count, model_cnt);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_write();
      step(1'b1, OP_SW);   // DECODE
      step(1'b1, OP_SW);   // MEM_ADDR
      step(1'b0, OP_SW);   // MEM_WRITE, waiting
      n_checks++;
      if (state_dbg !== S_MEM_WRITE || mem_write !== 1'b1)
         $display("FAIL reset_mid setup: state=%0d mem_write=%b expected state 6 mem_write 1", state_dbg, mem_write);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      model_cnt = '0;
      n_checks++;
      if (state_dbg !== S_IDLE || ctrl !== 16'h0 || {bus_err, illegal} !== 2'b00 || instr_count !== model_cnt)
         $display("FAIL reset_mid: state=%0d ctrl=%h count=%0d, expected state 0 ctrl 0 count 0",
                  state_dbg, ctrl, instr_count);
      else n_pass++;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, OP_R);
         n_checks++;
         if (state_dbg !== S_IDLE || ctrl !== 16'h0)
            $display("FAIL idle_hold: state=%0d ctrl=%h, expected state 0 ctrl 0", state_dbg, ctrl);
         else n_pass++;
      end
      run = 1'b1;
      step(1'b1, OP_J);
      run = 1'b0;
      n_checks++;
      if (state_dbg !== S_FETCH || ctrl !== exp_ctrl(S_FETCH, 1'b1, 1'b0))
         $display("FAIL restart: state=%0d ctrl=%h, expected state 1 ctrl %h", state_dbg, ctrl, exp_ctrl(S_FETCH, 1'b1, 1'b0));
      else n_pass++;
   endtask

   task automatic test_count_wrap();
      for (int n = 0; n < 256; n++) begin
         step(1'b1, OP_J);   // DECODE
         step(1'b1, OP_J);   // JUMP
         step(1'b1, OP_J);   // FETCH
         model_cnt = model_cnt + 1'b1;
         if (n >= 253) begin
            n_checks++;
            if (instr_count !== model_cnt || state_dbg !== S_FETCH)
               $display("FAIL count_wrap: count=%0d state=%0d, expected count=%0d state 1", instr_count, state_dbg, model_cnt);
            else n_pass++;
         end
      end
      n_checks++;
      if (instr_count !== '0) $display("FAIL count_wrap zero: got %0d expected 0", instr_count);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_lw_wait();
      test_beq();
      test_illegal_then_jump();
      test_sw_timeout();
      test_random();
      test_reset_mid_write();
      test_count_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
